// File: rtl/seq_adder_pkg.sv
// seq_adder shared types: FSM state enum and default operand width.
// Optional busy output is enabled by defining SEQ_ADDER_BUSY_EN.
package seq_adder_pkg;

  localparam int SEQ_ADDER_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/seq_adder_ctrl.sv
// seq_adder control: IDLE/BUSY FSM and step counter producing load/step/done.
// Optional busy output is enabled by defining SEQ_ADDER_BUSY_EN.
module seq_adder_ctrl
  import seq_adder_pkg::*;
#(
  parameter int n = SEQ_ADDER_W
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic load,
  output logic step,
  output logic done
`ifdef SEQ_ADDER_BUSY_EN
  ,
  output logic busy
`endif
);

  localparam int CW = $clog2(n) + 1;
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // state and step counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state, counter and datapath strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SEQ_ADDER_BUSY_EN
  assign busy = (state_q == BUSY);
`endif

endmodule

// File: rtl/seq_adder.sv
// seq_adder: unsigned radix-2 shift-add multiplier, one step per cycle.
// Optional busy output is enabled by defining SEQ_ADDER_BUSY_EN.
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int n = SEQ_ADDER_W
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [n-1:0]   mcand,
  input  logic [n-1:0]   mlier,
  output logic [2*n:0]   prodt_end,
  output logic           valid
`ifdef SEQ_ADDER_BUSY_EN
  ,
  output logic           busy
`endif
);

  logic load, step, done;

  logic [n-1:0] mcand_q, mcand_d;
  logic [2*n:0] work_q, work_d;
  logic [2*n:0] prodt_q, prodt_d;
  logic         valid_q, valid_d;
  logic [n:0]   sum;

  seq_adder_ctrl #(
    .n(n)
  ) u_ctrl (
    .clock(clock),
    .reset(reset),
    .start(start),
    .load (load),
    .step (step),
    .done (done)
`ifdef SEQ_ADDER_BUSY_EN
    ,
    .busy (busy)
`endif
  );

  // datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand_q <= '0;
      work_q  <= '0;
      prodt_q <= '0;
      valid_q <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      work_q  <= work_d;
      prodt_q <= prodt_d;
      valid_q <= valid_d;
    end
  end

  // load operands, or add-then-shift one multiplier bit
  always_comb begin
    mcand_d = mcand_q;
    work_d  = work_q;
    sum     = '0;
    unique case (1'b1)
      load: begin
        mcand_d = mcand;
        work_d  = {1'b0, {n{1'b0}}, mlier};
      end
      step: begin
        sum    = work_q[2*n:n]
               + (work_q[0] ? {1'b0, mcand_q} : '0);
        work_d = {1'b0, sum, work_q[n-1:1]};
      end
      default: ;
    endcase
    prodt_d = done ? work_d : prodt_q;
    valid_d = done;
  end

  assign prodt_end = prodt_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder: vector table, streaming,
// reset abort and randomized operands against a plain-arithmetic model.
module tb_seq_adder;

  localparam int N = 32;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mlier;
  logic [2*N:0]   prodt_end;
  logic           valid;
`ifdef SEQ_ADDER_BUSY_EN
  logic           busy;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  seq_adder #(.n(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .mcand    (mcand),
    .mlier    (mlier),
    .prodt_end(prodt_end),
    .valid    (valid)
`ifdef SEQ_ADDER_BUSY_EN
    ,
    .busy     (busy)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2*N:0] e;
    string        nm;
  } vec_t;

  function automatic logic [2*N:0] model(input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic [2*N-1:0] p;
    p = 64'(a) * 64'(b);
    return {1'b0, p};
  endfunction

  task automatic chk(input string nm, input logic [2*N:0] act,
                     input logic [2*N:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Operation from an idle DUT; operands scrambled mid-run.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N:0] e, input string nm);
    int lat;
    int bcnt;
    bit seen;
    @(negedge clock);
    start = 1'b1;
    mcand = a;
    mlier = b;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    mcand = $urandom;
    mlier = $urandom;
    lat  = 0;
    bcnt = 0;
    seen = 1'b0;
`ifdef SEQ_ADDER_BUSY_EN
    if (busy) bcnt++;
`endif
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clock);
      lat = k;
      @(negedge clock);
      if (valid) seen = 1'b1;
`ifdef SEQ_ADDER_BUSY_EN
      else if (busy) bcnt++;
`endif
    end
    chk({nm, " latency"}, 65'(lat), 65'(N));
    chk({nm, " product"}, prodt_end, e);
`ifdef SEQ_ADDER_BUSY_EN
    chk({nm, " busy cycles"}, 65'(bcnt), 65'(N));
`endif
    @(negedge clock);
    chk({nm, " valid pulse width"}, 65'(valid), 65'(0));
    chk({nm, " hold"}, prodt_end, e);
  endtask

  vec_t vt[6];

  initial begin
    int lat;
    int vcnt;
    bit seen;
    logic [N-1:0] ra, rb;

    vt[0] = '{32'd3, 32'd5, 65'd15, "small"};
    vt[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,
              65'h0_FFFF_FFFE_0000_0001, "max"};
    vt[2] = '{32'd0, 32'd0, 65'd0, "zero"};
    vt[3] = '{32'd1, 32'h8000_0000, 65'h8000_0000, "single bit"};
    vt[4] = '{32'hD7D7_D7D7, 32'hF7F7_F7F7,
              model(32'hD7D7_D7D7, 32'hF7F7_F7F7), "d7xf7"};
    vt[5] = '{32'hDDD8_5DDD, 32'hBBBB_EEBB,
              model(32'hDDD8_5DDD, 32'hBBBB_EEBB), "ddxbb"};

    reset = 1'b0;
    start = 1'b0;
    mcand = '0;
    mlier = '0;
    #1;
    chk("reset prodt_end", prodt_end, '0);
    chk("reset valid", 65'(valid), 65'(0));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_op(vt[i].a, vt[i].b, vt[i].e, vt[i].nm);

    // streaming with start held high
    @(negedge clock);
    start = 1'b1;
    mcand = vt[4].a;
    mlier = vt[4].b;
    @(posedge clock);
    @(negedge clock);
    mcand = vt[5].a;
    mlier = vt[5].b;
    lat = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clock);
      lat = k;
      @(negedge clock);
      if (valid) seen = 1'b1;
    end
    chk("stream first latency", 65'(lat), 65'(N));
    chk("stream first product", prodt_end, vt[4].e);
    @(negedge clock);
    chk("stream valid falls", 65'(valid), 65'(0));
    start = 1'b0;
    mcand = $urandom;
    mlier = $urandom;
    lat = 1;
    seen = 1'b0;
    for (int k = 2; k <= 45 && !seen; k++) begin
      @(posedge clock);
      lat = k;
      @(negedge clock);
      if (valid) seen = 1'b1;
    end
    chk("stream pulse spacing", 65'(lat), 65'(N + 1));
    chk("stream second product", prodt_end, vt[5].e);
    @(negedge clock);

    // reset in the middle of an operation
    start = 1'b1;
    mcand = 32'h1234_5678;
    mlier = 32'h9ABC_DEF0;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort prodt_end", prodt_end, '0);
    chk("abort valid", 65'(valid), 65'(0));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (valid) vcnt++;
    end
    chk("abort no valid", 65'(vcnt), 65'(0));
    run_op(32'd3, 32'd5, 65'd15, "after reset");

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = '1;
      run_op(ra, rb, model(ra, rb), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/seq_adder.md
SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 SHALL have parameter: n, default 32, operand width in bits (n >= 2).
REQ-002 SHALL have port: clock  input  1  rising-edge clock for all sequential logic.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  level request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port: mcand  input  n  unsigned multiplicand.
REQ-006 SHALL have port: mlier  input  n  unsigned multiplier.
REQ-007 SHALL have port: prodt_end  output  2n+1  registered product; bit 2n is the adder carry position.
REQ-008 SHALL have port: valid  output  1  one-cycle pulse marking a new result on prodt_end.

Function
REQ-009 SHALL implement an unsigned radix-2 shift-add multiplier with a 2n+1-bit working register {carry, upper n, lower n}.
REQ-010 SHALL have states IDLE and BUSY, plus an internal step counter of width clog2(n)+1.
REQ-011 In IDLE with start=1 at a clock edge, SHALL latch mcand, load the working register with {0, n zeros, mlier}, clear the counter and go to BUSY.
REQ-012 In IDLE with start=0, SHALL remain in IDLE.
REQ-013 Each BUSY edge SHALL do one step: if working[0]=1, {carry, upper} = upper + latched mcand; then shift the whole register right by one bit, inserting 0 at the MSB.
REQ-014 The edge performing step n SHALL write the final register value to prodt_end, set valid=1 and return to IDLE.
REQ-015 Latency SHALL be exactly n cycles from the start-accepting edge to valid=1; with start held high the throughput SHALL be one result every n+1 cycles.
REQ-016 valid SHALL be 1 for exactly one cycle per result and 0 otherwise.
REQ-017 prodt_end SHALL hold its value between results and SHALL change only on the completion edge or on reset.
REQ-018 prodt_end[2n-1:0] SHALL equal mcand*mlier for the operands sampled at start; prodt_end[2n] SHALL be 0.
REQ-019 start, mcand and mlier changes while in BUSY SHALL be ignored; the mcand latched at start SHALL be used.
REQ-020 Back-to-back operation: start=1 on the IDLE cycle after completion SHALL begin a new multiply with the current operands; valid SHALL fall on that edge.

Reset
REQ-021 reset=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, counter=0, working register=0, prodt_end=0 and valid=0.
REQ-022 Asserting reset while BUSY SHALL abort the operation with no valid pulse; after release, operation SHALL restart only through the IDLE start rule.

Configuration
REQ-023 With macro SEQ_ADDER_BUSY_EN defined, the module SHALL add output port busy (1 bit), equal to 1 exactly while in BUSY and 0 in reset; without the macro the port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-024 Package seq_adder_pkg SHALL hold the state enum type (IDLE, BUSY) and the default width constant (32).
REQ-025 The FSM and step counter SHALL be in one sub-module, seq_adder_ctrl, which outputs load, step and done strobes; the datapath SHALL stay in seq_adder.

Verification
REQ-026 Reset check: reset=0 mid-BUSY -> prodt_end=0, valid=0 at once, and no valid pulse until a new start after reset=1.
REQ-027 Small values: mcand=3, mlier=5, start=1 -> valid one cycle exactly 32 cycles after acceptance, prodt_end=15.
REQ-028 Maximum: mcand=mlier=0xFFFFFFFF -> prodt_end=0x0_FFFFFFFE_00000001, bit 64=0.
REQ-029 Zero and single bit: mcand=0, mlier=0 -> 0; mcand=1, mlier=0x80000000 -> 0x80000000.
REQ-030 Streaming: start held at 1 with mcand=0xD7D7D7D7, mlier=0xF7F7F7F7, then 0xDDD85DDD x 0xBBBBEEBB -> valid pulses every 33 cycles, each prodt_end equal to the golden 64-bit product, and operand changes in mid-operation do not affect the result in progress.
REQ-031 Config: build with SEQ_ADDER_BUSY_EN -> busy is high for exactly 32 cycles per operation; build without it -> results identical to the REQ-027 and REQ-028 runs.
